// File: rtl/mult_arbiter.sv
// ---------------------------------------------------------------------------
// mult_arbiter
//
// Purpose:
//   Shares one external WIDTH-bit shift-add multiplier datapath (A/B registers,
//   (WIDTH+1)-bit adder, X bit) between two requesters.
//   - Round-robin arbitration picks an owner.
//   - The owner's operands are latched and routed into the datapath.
//   - The datapath is then sequenced through these steps:
//     clear/load, WIDTH add/shift pairs, result capture, then a one-cycle done
//     pulse back to the owner.
//
// Configuration:
//   MULT_SIGNED_CORR_EN - when defined, the multiply is signed two's complement.
//                         The last add step becomes a subtract (dp_sub = dp_m).
//                         When undefined, the multiply is unsigned and dp_sub
//                         is tied to 0.
//
// Ports:
//   Clk       in   1        rising-edge clock
//   Reset     in   1        asynchronous active-high reset
//   req       in   2        per-requester request level, held until done seen
//   s0, b0    in   WIDTH    requester 0 multiplicand / multiplier
//   s1, b1    in   WIDTH    requester 1 multiplicand / multiplier
//   dp_m      in   1        datapath B[0], the current multiplier bit
//   dp_aval   in   WIDTH    datapath A register (upper half of the product)
//   dp_bval   in   WIDTH    datapath B register (lower half of the product)
//   dp_s      out  WIDTH    multiplicand routed to the datapath adder
//   dp_bin    out  WIDTH    multiplier routed to the datapath B load
//   dp_clr_ld out  1        clear A and X, load B from dp_bin
//   dp_add    out  1        A <= A + S
//   dp_sub    out  1        A <= A - S
//   dp_shift  out  1        arithmetic shift right of X:A:B
//   grant     out  2        one-hot owner, held from LOAD through DONE
//   done      out  2        one-cycle pulse to the owner when result is valid
//   result    out  2*WIDTH  {A,B} captured at the end of an operation
//   dbg_state out  3        current FSM state (state_e encoding)
//
// Handshake:
//   A requester raises req[i] and holds it until it sees done[i].
//   grant[i] tells it that its operands were taken. The operands are latched
//   when the arbiter leaves IDLE, so s/b may change freely once grant[i] is
//   high. req[i] still high in the cycle after done[i] counts as a new
//   request. A non-owner request simply waits and is served at the next IDLE.
// ---------------------------------------------------------------------------
module mult_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [1:0]         req,
    input  logic [WIDTH-1:0]   s0,
    input  logic [WIDTH-1:0]   b0,
    input  logic [WIDTH-1:0]   s1,
    input  logic [WIDTH-1:0]   b1,
    input  logic               dp_m,
    input  logic [WIDTH-1:0]   dp_aval,
    input  logic [WIDTH-1:0]   dp_bval,
    output logic [WIDTH-1:0]   dp_s,
    output logic [WIDTH-1:0]   dp_bin,
    output logic               dp_clr_ld,
    output logic               dp_add,
    output logic               dp_sub,
    output logic               dp_shift,
    output logic [1:0]         grant,
    output logic [1:0]         done,
    output logic [2*WIDTH-1:0] result,
    output logic [2:0]         dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_ADD     = 3'd2,
        S_SHIFT   = 3'd3,
        S_CAPTURE = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    state_e               state_q,      state_d;
    logic [CW-1:0]        cnt_q,        cnt_d;
    logic                 owner_q,      owner_d;
    logic                 last_owner_q, last_owner_d;
    logic [WIDTH-1:0]     s_q,          s_d;
    logic [WIDTH-1:0]     b_q,          b_d;
    logic [2*WIDTH-1:0]   result_q,     result_d;
    logic                 pick;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // last_owner resets to 1 so that requester 0 wins the first contested
    // arbitration after reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            s_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            s_q          <= s_d;
            b_q          <= b_d;
            result_q     <= result_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        s_d          = s_q;
        b_d          = b_q;
        result_d     = result_q;
        dp_clr_ld    = 1'b0;
        dp_add       = 1'b0;
        dp_sub       = 1'b0;
        dp_shift     = 1'b0;
        done         = 2'b00;

        // Contested: the requester that was not served last wins.
        // Uncontested: whichever one is asking wins.
        pick = (req[0] && req[1]) ? ~last_owner_q : req[1];

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    owner_d = pick;
                    // Operands are latched here, so later changes on the
                    // requester's inputs cannot disturb the operation.
                    s_d     = pick ? s1 : s0;
                    b_d     = pick ? b1 : b0;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                dp_clr_ld = 1'b1;
                state_d   = S_ADD;
            end

            S_ADD: begin
`ifdef MULT_SIGNED_CORR_EN
                // The multiplier's MSB carries negative weight in two's
                // complement, so the last partial product is subtracted.
                if (cnt_q == LAST_STEP) begin
                    dp_sub = dp_m;
                end else begin
                    dp_add = dp_m;
                end
`else
                dp_add = dp_m;
`endif
                state_d = S_SHIFT;
            end

            S_SHIFT: begin
                dp_shift = 1'b1;
                if (cnt_q == LAST_STEP) begin
                    cnt_d   = '0;
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = S_ADD;
                end
            end

            S_CAPTURE: begin
                result_d     = {dp_aval, dp_bval};
                last_owner_d = owner_q;
                state_d      = S_DONE;
            end

            S_DONE: begin
                done    = owner_q ? 2'b10 : 2'b01;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Grant and the operand routing are live for the whole operation
    // (LOAD through DONE) and parked at zero in IDLE.
    always_comb begin
        grant  = 2'b00;
        dp_s   = '0;
        dp_bin = '0;
        if (state_q != S_IDLE) begin
            grant  = owner_q ? 2'b10 : 2'b01;
            dp_s   = s_q;
            dp_bin = b_q;
        end
    end

    assign result    = result_q;
    assign dbg_state = state_q;

endmodule
